fir_ctrl: RTL and testbench

FIR_CTRL -- requirements
Module: fir_ctrl

---
 rtl/fir_ctrl_pkg.sv | 20 ++
 rtl/fir_ctrl_div.sv | 38 +++
 rtl/fir_ctrl.sv | 156 +++++++++++++++
 tb/tb_fir_ctrl.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_ctrl_pkg.sv
// fir_ctrl_pkg: shared types and constants for the FIR control block.
package fir_ctrl_pkg;

  localparam int NTAPS        = 16;
  localparam int WARMUP_TICKS = 18;
  localparam int TCNT_W       = 5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WARMUP = 2'd1,
    ST_RUN    = 2'd2,
    ST_BAD    = 2'd3
  } state_e;

  // True for the states in which the FIR datapath is enabled.
  function automatic logic is_active(input state_e s);
    return (s == ST_WARMUP) || (s == ST_RUN);
  endfunction

endpackage

// File: rtl/fir_ctrl_div.sv
// fir_ctrl_div: sample-period divider. Counts 0..i_div while enabled and
// emits a registered one-cycle tick on the cycle after the count hits i_div.
module fir_ctrl_div
  import fir_ctrl_pkg::*;
#(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic             i_clr,
  input  logic [DIV_W-1:0] i_div,
  output logic             o_tick
);

  logic [DIV_W-1:0] r_cnt;
  logic             r_tick;

  // Divider counter with wrap at i_div; tick registered alongside the wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (!i_en || i_clr) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (r_cnt == i_div) begin
      r_cnt  <= '0;
      r_tick <= 1'b1;
    end else begin
      r_cnt  <= r_cnt + 1'b1;
      r_tick <= 1'b0;
    end
  end

  assign o_tick = r_tick;

endmodule

// File: rtl/fir_ctrl.sv
// fir_ctrl: FIR filter control (IDLE/WARMUP/RUN sequencer, sample divider,
// coefficient bank). Build option FIR_CTRL_SHADOW_EN selects a double-buffered
// coefficient bank swapped on commit; without it a single bank is written
// directly and only while idle.
module fir_ctrl
  import fir_ctrl_pkg::*;
#(
  parameter int DIV_W = 16,
  parameter int CW    = 12
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                stop,
  input  logic [DIV_W-1:0]    div,
  input  logic                coef_we,
  input  logic [3:0]          coef_addr,
  input  logic [CW-1:0]       coef_wdata,
  input  logic                commit,
  output logic                en_fir,
  output logic                sample_tick,
  output logic [NTAPS*CW-1:0] coef_flat,
  output logic                out_valid,
  output logic                commit_pend,
  output logic [1:0]          state_o,
  output logic                cfg_err
);

  state_e              r_state;
  state_e              w_state_nxt;
  logic                r_en_fir;
  logic                r_out_valid;
  logic                r_cfg_err;
  logic [DIV_W-1:0]    r_div_q;
  logic [TCNT_W-1:0]   r_tick_cnt;
  logic [NTAPS*CW-1:0] r_active;
  logic                w_tick;
  logic                w_enter_warm;
  logic                w_en_nxt;
  logic                w_cfg_set;

  // Next-state decode; stop overrides everything, unused encoding recovers.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (start) w_state_nxt = ST_WARMUP;
      ST_WARMUP: if (w_tick && (r_tick_cnt == TCNT_W'(WARMUP_TICKS - 1))) w_state_nxt = ST_RUN;
      ST_RUN:    w_state_nxt = ST_RUN;
      default:   w_state_nxt = ST_IDLE;
    endcase
    if (stop) w_state_nxt = ST_IDLE;
  end

  assign w_enter_warm = (r_state == ST_IDLE) && (w_state_nxt == ST_WARMUP);
  assign w_en_nxt     = is_active(w_state_nxt);

  // State register with registered enable/valid, period capture and warmup tick count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_en_fir    <= 1'b0;
      r_out_valid <= 1'b0;
      r_div_q     <= '0;
      r_tick_cnt  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_en_fir    <= w_en_nxt;
      r_out_valid <= (w_state_nxt == ST_RUN);
      if (w_enter_warm) begin
        r_div_q    <= div;
        r_tick_cnt <= '0;
      end else if ((r_state == ST_WARMUP) && w_tick) begin
        r_tick_cnt <= r_tick_cnt + 1'b1;
      end
    end
  end

  fir_ctrl_div #(
    .DIV_W (DIV_W)
  ) u_div (
    .clk    (clk),
    .rst_n  (rst),
    .i_en   (w_en_nxt),
    .i_clr  (w_enter_warm),
    .i_div  (r_div_q),
    .o_tick (w_tick)
  );

`ifdef FIR_CTRL_SHADOW_EN
  logic [NTAPS*CW-1:0] r_shadow;
  logic [NTAPS*CW-1:0] w_shadow_nxt;
  logic                r_pend;
  logic                w_swap;

  // Shadow contents including a write landing on this edge, so a swap sees it.
  always_comb begin
    w_shadow_nxt = r_shadow;
    if (coef_we) w_shadow_nxt[int'(coef_addr)*CW +: CW] = coef_wdata;
  end

  // Swap immediately when idle, otherwise on the edge that consumes a sample tick.
  assign w_swap    = r_pend && ((r_state == ST_IDLE) || w_tick);
  assign w_cfg_set = 1'b0;

  // Shadow/active banks and the pending-swap flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_shadow <= '0;
      r_active <= '0;
      r_pend   <= 1'b0;
    end else begin
      r_shadow <= w_shadow_nxt;
      if (w_swap) r_active <= w_shadow_nxt;
      if (w_swap)      r_pend <= 1'b0;
      else if (commit) r_pend <= 1'b1;
    end
  end

  assign commit_pend = r_pend;
`else
  logic w_unused_commit;

  assign w_unused_commit = commit;
  assign w_cfg_set       = coef_we && (r_state != ST_IDLE);

  // Single bank, writable only while the filter is idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_active <= '0;
    end else if (coef_we && (r_state == ST_IDLE)) begin
      r_active[int'(coef_addr)*CW +: CW] <= coef_wdata;
    end
  end

  assign commit_pend = 1'b0;
`endif

  // Sticky configuration error; a new illegal write outranks a clearing start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cfg_err <= 1'b0;
    end else if (w_cfg_set) begin
      r_cfg_err <= 1'b1;
    end else if (start) begin
      r_cfg_err <= 1'b0;
    end
  end

  assign en_fir      = r_en_fir;
  assign sample_tick = w_tick;
  assign out_valid   = r_out_valid;
  assign state_o     = r_state;
  assign cfg_err     = r_cfg_err;
  assign coef_flat   = r_active;

endmodule

// File: tb/tb_fir_ctrl.sv
// tb_fir_ctrl: directed + randomized bench for fir_ctrl against a rule-level
// reference model (tick times derived arithmetically from cycles since enable).
module tb_fir_ctrl;

  localparam int DIV_W = 16;
  localparam int CW    = 12;
  localparam int NT    = 16;
  localparam int FW    = NT * CW;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic [DIV_W-1:0] div = '0;
  logic             coef_we = 1'b0;
  logic [3:0]       coef_addr = '0;
  logic [CW-1:0]    coef_wdata = '0;
  logic             commit = 1'b0;
  logic             en_fir;
  logic             sample_tick;
  logic [FW-1:0]    coef_flat;
  logic             out_valid;
  logic             commit_pend;
  logic [1:0]       state_o;
  logic             cfg_err;

  fir_ctrl #(.DIV_W(DIV_W), .CW(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .stop        (stop),
    .div         (div),
    .coef_we     (coef_we),
    .coef_addr   (coef_addr),
    .coef_wdata  (coef_wdata),
    .commit      (commit),
    .en_fir      (en_fir),
    .sample_tick (sample_tick),
    .coef_flat   (coef_flat),
    .out_valid   (out_valid),
    .commit_pend (commit_pend),
    .state_o     (state_o),
    .cfg_err     (cfg_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: state 0 idle, 1 warmup, 2 run; m_t = edges since enable.
  int m_state, m_t, m_div;
  bit m_pend, m_err, e_tick;
  int m_act[NT];
  int m_sh[NT];

  int c, nt, last;
  bit done;

  task automatic chk(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [FW-1:0] model_flat();
    logic [FW-1:0] v;
    v = '0;
    for (int i = 0; i < NT; i++) v[i*CW +: CW] = CW'(m_act[i]);
    return v;
  endfunction

  task automatic model_reset();
    m_state = 0; m_t = 0; m_div = 0;
    m_pend = 0; m_err = 0; e_tick = 0;
    for (int i = 0; i < NT; i++) begin
      m_act[i] = 0;
      m_sh[i]  = 0;
    end
  endtask

  task automatic model_edge();
    int old_state;
    bit old_tick, old_pend, swap;
    if (!rst) begin
      model_reset();
      return;
    end
    old_state = m_state;
    old_tick  = e_tick;
    old_pend  = m_pend;
`ifdef FIR_CTRL_SHADOW_EN
    if (coef_we) m_sh[coef_addr] = int'(coef_wdata);
    swap = old_pend && ((old_state == 0) || old_tick);
    if (swap) m_act = m_sh;
    if (swap) m_pend = 0;
    else if (commit) m_pend = 1;
    if (start) m_err = 0;
`else
    swap = 0;
    if (start) m_err = 0;
    if (coef_we) begin
      if (old_state == 0) m_act[coef_addr] = int'(coef_wdata);
      else m_err = 1;
    end
`endif
    if (stop) m_state = 0;
    else if (old_state == 0 && start) begin
      m_state = 1;
      m_div   = int'(div);
      m_t     = 0;
    end else if (old_state != 0) begin
      m_t++;
      if (old_state == 1 && m_t == 18 * (m_div + 1) + 1) m_state = 2;
    end
    e_tick = (m_state != 0) && (m_t > 0) && ((m_t % (m_div + 1)) == 0);
  endtask

  task automatic check_all();
    chk("state_o", state_o, m_state);
    chk("en_fir", en_fir, m_state != 0);
    chk("sample_tick", sample_tick, e_tick);
    chk("out_valid", out_valid, m_state == 2);
    chk("commit_pend", commit_pend, m_pend);
    chk("cfg_err", cfg_err, m_err);
    chk("coef_flat", coef_flat, model_flat());
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
    start = 0; stop = 0; coef_we = 0; commit = 0;
  endtask

  initial begin
    model_reset();
    rst = 0;
    repeat (3) @(posedge clk);
    #1;
    check_all();
    chk("rst_coef_zero", coef_flat, '0);
    chk("rst_en_fir", en_fir, 1'b0);
    rst = 1;
    step();

    // Load taps n+1 and commit while idle.
    for (int n = 0; n < NT; n++) begin
      coef_we = 1; coef_addr = 4'(n); coef_wdata = CW'(n + 1);
      step();
    end
    commit = 1;
    step();
`ifdef FIR_CTRL_SHADOW_EN
    chk("commit_pend_set", commit_pend, 1'b1);
`else
    chk("commit_pend_tied", commit_pend, 1'b0);
`endif
    step();
    chk("tap5_after_commit", coef_flat[5*CW +: CW], 12'd6);
    chk("pend_clear_idle", commit_pend, 1'b0);

    // div=3: tick every 4 clocks, RUN after 18 ticks.
    div = 16'd3; start = 1;
    step();
    chk("en_rise", en_fir, 1'b1);
    c = 0; nt = 0; last = 0; done = 0;
    for (int k = 0; k < 200 && !done; k++) begin
      step();
      c++;
      if (out_valid) done = 1;
      else if (sample_tick) begin
        if (nt == 0) chk("first_tick_delay", c, 4);
        else chk("tick_period", c - last, 4);
        last = c;
        nt++;
      end
    end
    chk("warmup_ticks", nt, 18);
    chk("out_valid_run", out_valid, 1'b1);
    chk("state_run", state_o, 2'd2);

    // Write tap0 during RUN with a commit.
    coef_we = 1; coef_addr = 4'd0; coef_wdata = 12'h7FF; commit = 1;
    step();
`ifdef FIR_CTRL_SHADOW_EN
    chk("tap0_hold_after_commit", coef_flat[CW-1:0], 12'd1);
    for (int k = 0; k < 10 && !sample_tick; k++) step();
    chk("tick_seen", sample_tick, 1'b1);
    chk("tap0_hold_at_tick", coef_flat[CW-1:0], 12'd1);
    step();
    chk("tap0_swapped", coef_flat[CW-1:0], 12'h7FF);
    chk("pend_clear_tick", commit_pend, 1'b0);
    stop = 1;
    step();
`else
    chk("tap0_unchanged_run", coef_flat[CW-1:0], 12'd1);
    chk("cfg_err_set", cfg_err, 1'b1);
    stop = 1;
    step();
    chk("idle_after_stop", state_o, 2'd0);
    chk("cfg_err_sticky", cfg_err, 1'b1);
    div = 16'd1; start = 1;
    step();
    chk("cfg_err_cleared", cfg_err, 1'b0);
    stop = 1;
    step();
`endif

    // start+stop together in IDLE; stop during WARMUP.
    start = 1; stop = 1;
    step();
    chk("startstop_idle", state_o, 2'd0);
    chk("startstop_en", en_fir, 1'b0);
    div = 16'd2; start = 1;
    step();
    for (int k = 0; k < 20; k++) begin
      step();
      chk("warmup_no_valid", out_valid, 1'b0);
    end
    stop = 1;
    step();
    chk("stop_warmup_idle", state_o, 2'd0);
    chk("stop_warmup_valid", out_valid, 1'b0);

    // Randomized traffic.
    for (int k = 0; k < 900; k++) begin
      start      = ($urandom % 40) == 0;
      stop       = ($urandom % 160) == 0;
      coef_we    = ($urandom % 4) == 0;
      coef_addr  = 4'($urandom);
      coef_wdata = CW'($urandom);
      commit     = ($urandom % 15) == 0;
      div        = DIV_W'($urandom_range(0, 4));
      step();
    end

    // Async reset mid-RUN with a pending swap.
    stop = 1;
    step();
    div = 16'd5; start = 1;
    step();
    for (int k = 0; k < 200 && state_o != 2'd2; k++) step();
    chk("reach_run", state_o, 2'd2);
    for (int k = 0; k < 10 && !sample_tick; k++) step();
`ifdef FIR_CTRL_SHADOW_EN
    coef_we = 1; coef_addr = 4'd3; coef_wdata = 12'h123; commit = 1;
    step();
    chk("pend_before_rst", commit_pend, 1'b1);
`else
    step();
`endif
    #2;
    rst = 0;
    #1;
    model_reset();
    chk("arst_en_fir", en_fir, 1'b0);
    chk("arst_tick", sample_tick, 1'b0);
    chk("arst_valid", out_valid, 1'b0);
    chk("arst_pend", commit_pend, 1'b0);
    chk("arst_state", state_o, 2'd0);
    chk("arst_cfg_err", cfg_err, 1'b0);
    chk("arst_coef", coef_flat, '0);
    step();
    rst = 1;
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
